// File: rtl/pll_clk_sequencer_if.sv
// Control/status bundle between the PLL clock sequencer and the PLL wrapper side.
interface pll_clk_sequencer_if #(
   parameter int unsigned NUM_CLK = 3
);
   logic               pll_lock;
   logic [NUM_CLK-1:0] ch_req;
   logic               pll_reset;
   logic [NUM_CLK-1:0] enclk;
   logic               ready;
   logic [7:0]         relock_cnt;
   logic               tmo_flag;
   logic [2:0]         state;

   modport master (
      output pll_lock, ch_req,
      input  pll_reset, enclk, ready, relock_cnt, tmo_flag, state
   );

   modport slave (
      input  pll_lock, ch_req,
      output pll_reset, enclk, ready, relock_cnt, tmo_flag, state
   );
endinterface

// File: rtl/pll_clk_sequencer.sv
// PLL power-up/relock sequencer: resets the PLL, filters lock, enables outputs one by one,
// and tears everything down and retries on lock loss or lock timeout.
module pll_clk_sequencer #(
   parameter int unsigned NUM_CLK   = 3,
   parameter int unsigned RST_CYC   = 16,
   parameter int unsigned LOCK_FILT = 64,
   parameter int unsigned EN_GAP    = 8,
   parameter int unsigned LOCK_TMO  = 65536
) (
   input  logic                clkin,
   input  logic                rst_n,
   pll_clk_sequencer_if.slave  bus
);

   localparam int unsigned MAX_A   = (RST_CYC > LOCK_FILT) ? RST_CYC : LOCK_FILT;
   localparam int unsigned MAX_B   = (EN_GAP > LOCK_TMO) ? EN_GAP : LOCK_TMO;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

   typedef enum logic [2:0] {
      S_RST  = 3'd0,
      S_WAIT = 3'd1,
      S_FILT = 3'd2,
      S_SEQ  = 3'd3,
      S_RUN  = 3'd4,
      S_LOST = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_CLK-1:0] enclk_q, enclk_d;
   logic [7:0]         relock_q, relock_d;
   logic               tmo_q, tmo_d;
   logic               ready_q;
   logic               pll_reset_q;
   logic               lock_q1;
   logic               lock_s;

   // Next-state, phase counter, channel index and sticky status
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      enclk_d  = enclk_q;
      relock_d = relock_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_RST: begin
            if (cnt_q == CNT_W'(RST_CYC - 1)) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (lock_s) begin
               state_d = S_FILT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TMO - 1)) begin
               state_d = S_RST;
               cnt_d   = '0;
               tmo_d   = 1'b1;
            end
         end
         S_FILT: begin
            if (!lock_s) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
               state_d = S_SEQ;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_SEQ: begin
            if (!lock_s) begin
               state_d = S_LOST;
            end else if (cnt_q == CNT_W'(EN_GAP - 1)) begin
               cnt_d          = '0;
               enclk_d[idx_q] = bus.ch_req[idx_q];
               if (idx_q == IDX_W'(NUM_CLK - 1)) begin
                  state_d = S_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d = S_LOST;
            end else begin
               enclk_d = bus.ch_req;
            end
         end
         S_LOST: begin
            state_d = S_RST;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_RST;
            cnt_d   = '0;
         end
      endcase
      // Lock loss overrides any enable update made above
      if (state_d == S_LOST && state_q != S_LOST) begin
         enclk_d  = '0;
         cnt_d    = '0;
         relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
      end
   end

   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_q     <= S_RST;
         cnt_q       <= '0;
         idx_q       <= '0;
         enclk_q     <= '0;
         relock_q    <= '0;
         tmo_q       <= 1'b0;
         ready_q     <= 1'b0;
         pll_reset_q <= 1'b1;
         lock_q1     <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         enclk_q     <= enclk_d;
         relock_q    <= relock_d;
         tmo_q       <= tmo_d;
         ready_q     <= (state_d == S_RUN);
         pll_reset_q <= (state_d == S_RST);
         lock_q1     <= bus.pll_lock;
         lock_s      <= lock_q1;
      end
   end

   assign bus.pll_reset  = pll_reset_q;
   assign bus.enclk      = enclk_q;
   assign bus.ready      = ready_q;
   assign bus.relock_cnt = relock_q;
   assign bus.tmo_flag   = tmo_q;
   assign bus.state      = 3'(state_q);

endmodule
